// File: rtl/posit_pd_decode_pipe.sv
// Multi-lane pipelined posit decoder. Each lane turns a packed posit word into
// {scale, fraction, sign, zero, nar}; guard/round/sticky are always zero since
// decoding is exact. A saturating counter tallies NaR lanes seen at the output.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// in the cycle before it. in_valid/in_data must hold until in_ready is seen;
// out_* hold stable while out_valid=1 and out_ready=0. in_ready may depend
// combinationally on out_ready.
module posit_pd_decode_pipe #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1,
  parameter int LANES       = 4,
  parameter int STAGES      = 2,
  localparam int SW = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
  localparam int FW = POSIT_WIDTH - POSIT_ES - 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*POSIT_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*SW-1:0]      out_scale,
  output logic [LANES*FW-1:0]      out_fraction,
  output logic [LANES-1:0]         out_sign,
  output logic [LANES-1:0]         out_zero,
  output logic [LANES-1:0]         out_nar,
  output logic [3*LANES-1:0]       out_grs,
  output logic [15:0]              nar_count
);

  localparam int N  = POSIT_WIDTH;
  // Bits left after the shortest possible regime (one bit plus terminator).
  localparam int RW = N - 3;
  // Per-lane payload: {scale, fraction, sign, zero, nar}.
  localparam int LW = SW + FW + 3;
  localparam int PW = LANES * LW;

  function automatic logic [LW-1:0] decode_lane(input logic [N-1:0] w);
    logic [N-2:0]    body;
    logic [RW-1:0]   rest;
    logic            lead;
    logic            run_on;
    int              m;
    int              r;
    int              e;
    logic [SW-1:0]   sc;
    // Negative posits are decoded from the magnitude (two's complement).
    body   = w[N-1] ? (~w[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : w[N-2:0];
    lead   = body[N-2];
    m      = 0;
    run_on = 1'b1;
    for (int k = N - 2; k >= 0; k--) begin
      if (run_on && (body[k] == lead)) m = m + 1;
      else run_on = 1'b0;
    end
    r = lead ? (m - 1) : -m;
    // Drop regime and terminator; the two low bits of the shifted body are
    // always zero because at least two bits were shifted out.
    rest = RW'((body << (m + 1)) >> 2);
    e    = 0;
    for (int k = 0; k < POSIT_ES; k++) begin
      e = (e << 1) | int'(rest[RW-1-k]);
    end
    sc = SW'(r * (1 << POSIT_ES) + e);
    decode_lane = {sc, rest[FW-1:0], w[N-1], 1'b0, 1'b0};
    if (w == '0) decode_lane = {{(LW-2){1'b0}}, 2'b10};
    if (w == {1'b1, {(N-1){1'b0}}}) decode_lane = {{(LW-3){1'b0}}, 3'b101};
  endfunction

  logic [PW-1:0]     w_dec;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] r_vld;
  logic [PW-1:0]     r_data [STAGES];
  logic [15:0]       r_nar_count;
  logic [15:0]       w_nar_pop;
  logic [16:0]       w_nar_sum;

  // Full combinational decode of all lanes ahead of stage 0.
  always_comb begin
    w_dec = '0;
    for (int l = 0; l < LANES; l++) begin
      w_dec[l*LW +: LW] = decode_lane(in_data[l*N +: N]);
    end
  end

  // A stage loads when it or any later stage is empty, or the output drains.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_load[k] = out_ready;
      for (int j = 0; j < STAGES; j++) begin
        if ((j >= k) && !r_vld[j]) w_load[k] = 1'b1;
      end
    end
  end

  // Pipeline valid and data registers; bubbles collapse as stages load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0]  <= in_valid;
        r_data[0] <= w_dec;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_grs   = '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign out_scale[l*SW +: SW]    = r_data[STAGES-1][l*LW + FW + 3 +: SW];
    assign out_fraction[l*FW +: FW] = r_data[STAGES-1][l*LW + 3 +: FW];
    assign out_sign[l]              = r_data[STAGES-1][l*LW + 2];
    assign out_zero[l]              = r_data[STAGES-1][l*LW + 1];
    assign out_nar[l]               = r_data[STAGES-1][l*LW];
  end

  // Number of NaR lanes in the beat currently at the output.
  always_comb begin
    w_nar_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_nar_pop = w_nar_pop + {15'd0, out_nar[l]};
    end
  end

  assign w_nar_sum = {1'b0, r_nar_count} + {1'b0, w_nar_pop};

  // Saturating NaR counter, advanced on each output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nar_count <= '0;
    end else if (out_valid && out_ready) begin
      r_nar_count <= w_nar_sum[16] ? 16'hFFFF : w_nar_sum[15:0];
    end
  end

  assign nar_count = r_nar_count;

endmodule
